// File: rtl/pump_rotation_ctrl.sv
// Tank fill controller for N pumps: one lead pump with fill hysteresis between
// the low (I) and high (S) sensors, every available pump below the low mark.
module pump_rotation_ctrl #(
    parameter int N_PUMPS = 2,
    parameter int COUNT_W = 8,
    localparam int LW     = (N_PUMPS > 1) ? $clog2(N_PUMPS) : 1
) (
    input  logic               Clock,
    input  logic               R,
    input  logic               S,
    input  logic               I,
    input  logic [N_PUMPS-1:0] Avail,
    output logic [N_PUMPS-1:0] B,
    output logic [LW-1:0]      Lead,
    output logic               Filling,
    output logic               SensorErr,
    output logic [COUNT_W-1:0] FillCount
);

    localparam logic [LW:0] NP = (LW+1)'(N_PUMPS);

    typedef enum logic {IDLE = 1'b0, FILLING = 1'b1} fill_e;

    fill_e              filling_q, filling_d;
    logic [LW-1:0]      lead_q, lead_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;

    logic fault, below, mid, full, fill_end, lead_lost;

    // Round-robin search starting just after x; x itself is tried last, so an
    // empty mask leaves the lead where it was.
    function automatic logic [LW-1:0] next_avail(input logic [LW-1:0] x,
                                                 input logic [N_PUMPS-1:0] av);
        logic [LW-1:0] res;
        logic [LW:0]   t;
        logic          found;
        res   = x;
        found = 1'b0;
        for (int k = 1; k <= N_PUMPS; k++) begin
            t = {1'b0, x} + (LW+1)'(k);
            if (t >= NP) t = t - NP;
            if (!found && av[t[LW-1:0]]) begin
                res   = t[LW-1:0];
                found = 1'b1;
            end
        end
        return res;
    endfunction

    assign fault     = S & ~I;
    assign below     = ~I & ~S;
    assign mid       = I & ~S;
    assign full      = I & S;
    assign fill_end  = (filling_q == FILLING) & full;
    assign lead_lost = ~Avail[lead_q] & (|Avail);

    always_ff @(posedge Clock) begin
        if (R) begin
            filling_q <= IDLE;
            lead_q    <= '0;
            cnt_q     <= '0;
        end else begin
            filling_q <= filling_d;
            lead_q    <= lead_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        filling_d = filling_q;
        lead_d    = lead_q;
        cnt_d     = cnt_q;
        if (!fault) begin
            if (below)
                filling_d = FILLING;
            else if (fill_end)
                filling_d = IDLE;
            // A fill end and a lost lead coincide into a single advance.
            if (fill_end || lead_lost)
                lead_d = next_avail(lead_q, Avail);
            if (fill_end && (cnt_q != '1))
                cnt_d = cnt_q + COUNT_W'(1);
        end
    end

    always_comb begin
        B = '0;
        if (!R) begin
            if (below)
                B = Avail;
            else if (mid && (filling_q == FILLING))
                B = (N_PUMPS'(1) << lead_q) & Avail;
        end
    end

    assign SensorErr = fault;
    assign Lead      = lead_q;
    assign Filling   = (filling_q == FILLING);
    assign FillCount = cnt_q;

endmodule

// File: tb/tb_pump_rotation_ctrl.sv
// Bench for pump_rotation_ctrl (N=3): directed vector table, then random
// stimulus against a sensor-rule reference model; two counter widths in parallel.
module tb_pump_rotation_ctrl;

    logic       Clock = 1'b0;
    logic       R = 1'b1, S = 1'b0, I = 1'b0;
    logic [2:0] Avail = 3'b111;

    logic [2:0] b_a, b_b;
    logic [1:0] lead_a, lead_b;
    logic       fill_a, fill_b, err_a, err_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;

    always #5 Clock = ~Clock;

    pump_rotation_ctrl #(.N_PUMPS(3), .COUNT_W(8)) dut_a (
        .Clock(Clock), .R(R), .S(S), .I(I), .Avail(Avail),
        .B(b_a), .Lead(lead_a), .Filling(fill_a), .SensorErr(err_a), .FillCount(cnt_a));

    pump_rotation_ctrl #(.N_PUMPS(3), .COUNT_W(2)) dut_b (
        .Clock(Clock), .R(R), .S(S), .I(I), .Avail(Avail),
        .B(b_b), .Lead(lead_b), .Filling(fill_b), .SensorErr(err_b), .FillCount(cnt_b));

    typedef struct {
        bit       r, s, i;
        bit [2:0] av;
        bit [2:0] b;
        bit       fill;
        int       lead;
        int       cnt;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   failures = 0;
    int   row = 0;

    // captured DUT values: combinational before the edge, registered after
    int cb_a, cb_b, ce_a, ce_b, rl_a, rl_b, rf_a, rf_b, rc_a, rc_b;

    // reference model state
    bit m_fill;
    int m_lead, m_cnt;
    int x_b, x_err;

    function automatic int nav(input int x, input bit [2:0] av);
        for (int k = 1; k <= 3; k++)
            if (av[(x + k) % 3]) return (x + k) % 3;
        return x;
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_comb(input bit r, s, i, input bit [2:0] av);
        x_err = (s && !i) ? 1 : 0;
        if (r || (s && !i) || (s && i)) x_b = 0;
        else if (!i && !s)              x_b = int'(av);
        else                            x_b = m_fill ? int'(av & (3'b001 << m_lead)) : 0;
    endtask

    task automatic model_edge(input bit r, s, i, input bit [2:0] av);
        bit fe;
        if (r) begin
            m_fill = 0; m_lead = 0; m_cnt = 0;
        end else if (!(s && !i)) begin
            fe = m_fill && s && i;
            if (!i && !s) m_fill = 1;
            if (fe) begin m_fill = 0; m_cnt++; end
            if (fe || (av != 3'b000 && !av[m_lead])) m_lead = nav(m_lead, av);
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s step=%0d got=%0d want=%0d", nm, row, act, exp);
        end
    endtask

    task automatic step(input bit r, s, i, input bit [2:0] av);
        @(negedge Clock);
        R = r; S = s; I = i; Avail = av;
        #1;
        cb_a = int'(b_a); cb_b = int'(b_b); ce_a = int'(err_a); ce_b = int'(err_b);
        model_comb(r, s, i, av);
        @(posedge Clock);
        model_edge(r, s, i, av);
        #1;
        rl_a = int'(lead_a); rl_b = int'(lead_b);
        rf_a = int'(fill_a); rf_b = int'(fill_b);
        rc_a = int'(cnt_a);  rc_b = int'(cnt_b);
    endtask

    task automatic tv(input bit r, s, i, input bit [2:0] av, input bit [2:0] b,
                      input bit fill, input int lead, input int cnt);
        vec_t v;
        v.r = r; v.s = s; v.i = i; v.av = av; v.b = b;
        v.fill = fill; v.lead = lead; v.cnt = cnt;
        tbl.push_back(v);
    endtask

    initial begin
        //  r  s  i  avail   B      fill lead cnt (after edge)
        tv(1, 0, 0, 3'b111, 3'b000, 0, 0, 0);
        tv(0, 0, 0, 3'b111, 3'b111, 1, 0, 0);
        tv(0, 0, 1, 3'b111, 3'b001, 1, 0, 0);
        tv(0, 1, 1, 3'b111, 3'b000, 0, 1, 1);
        tv(0, 0, 1, 3'b111, 3'b000, 0, 1, 1);
        tv(0, 0, 0, 3'b111, 3'b111, 1, 1, 1);
        tv(0, 0, 1, 3'b111, 3'b010, 1, 1, 1);
        tv(0, 1, 1, 3'b111, 3'b000, 0, 2, 2);
        tv(0, 0, 0, 3'b111, 3'b111, 1, 2, 2);
        tv(0, 0, 1, 3'b111, 3'b100, 1, 2, 2);
        tv(0, 1, 1, 3'b111, 3'b000, 0, 0, 3);
        tv(0, 0, 0, 3'b111, 3'b111, 1, 0, 3);
        tv(0, 1, 1, 3'b111, 3'b000, 0, 1, 4);
        tv(0, 0, 0, 3'b111, 3'b111, 1, 1, 4);
        tv(0, 0, 1, 3'b101, 3'b000, 1, 2, 4);
        tv(0, 0, 1, 3'b101, 3'b100, 1, 2, 4);
        tv(0, 1, 1, 3'b101, 3'b000, 0, 0, 5);
        tv(0, 0, 0, 3'b111, 3'b111, 1, 0, 5);
        for (int k = 0; k < 4; k++) tv(0, 1, 0, 3'b111, 3'b000, 1, 0, 5);
        tv(0, 1, 0, 3'b110, 3'b000, 1, 0, 5);
        tv(0, 0, 1, 3'b111, 3'b001, 1, 0, 5);
        tv(0, 1, 1, 3'b111, 3'b000, 0, 1, 6);
        tv(0, 0, 0, 3'b111, 3'b111, 1, 1, 6);
        tv(0, 1, 1, 3'b111, 3'b000, 0, 2, 7);
        tv(0, 0, 0, 3'b111, 3'b111, 1, 2, 7);
        tv(1, 0, 0, 3'b111, 3'b000, 0, 0, 0);
        tv(1, 1, 0, 3'b111, 3'b000, 0, 0, 0);
        tv(0, 0, 1, 3'b110, 3'b000, 0, 1, 0);
        tv(0, 0, 0, 3'b000, 3'b000, 1, 1, 0);
        tv(0, 1, 1, 3'b000, 3'b000, 0, 1, 1);
        tv(0, 1, 1, 3'b111, 3'b000, 0, 1, 1);

        m_fill = 0; m_lead = 0; m_cnt = 0;
        foreach (tbl[n]) begin
            row = n;
            step(tbl[n].r, tbl[n].s, tbl[n].i, tbl[n].av);
            chk("B_w8",       cb_a, int'(tbl[n].b));
            chk("B_w2",       cb_b, int'(tbl[n].b));
            chk("SensorErr",  ce_a, (tbl[n].s && !tbl[n].i) ? 1 : 0);
            chk("Filling",    rf_a, int'(tbl[n].fill));
            chk("Lead",       rl_a, tbl[n].lead);
            chk("Lead_w2",    rl_b, tbl[n].lead);
            chk("FillCnt_w8", rc_a, tbl[n].cnt);
            chk("FillCnt_w2", rc_b, sat(tbl[n].cnt, 3));
        end

        // random phase against the reference model
        step(1, 0, 0, 3'b111);
        for (int n = 0; n < 400; n++) begin
            bit       r, s, i;
            bit [2:0] av;
            row = 1000 + n;
            r  = ($urandom_range(0, 39) == 0);
            s  = $urandom_range(0, 1) == 1;
            i  = ($urandom_range(0, 3) != 0) || s;
            if ($urandom_range(0, 9) == 0) i = 1'b0;
            av = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b111;
            step(r, s, i, av);
            chk("rnd_B",       cb_a, x_b);
            chk("rnd_B_w2",    cb_b, x_b);
            chk("rnd_Err",     ce_b, x_err);
            chk("rnd_Filling", rf_a, int'(m_fill));
            chk("rnd_Fill_w2", rf_b, int'(m_fill));
            chk("rnd_Lead",    rl_a, m_lead);
            chk("rnd_Lead_w2", rl_b, m_lead);
            chk("rnd_Cnt_w8",  rc_a, sat(m_cnt, 255));
            chk("rnd_Cnt_w2",  rc_b, sat(m_cnt, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
